// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit
//   M-stage load/store unit: turns a load/store into a registered req/ack
//   transaction and stalls the pipeline until the transaction completes.
// Revision: 1.0  initial release
// ============================================================================
module mem_access_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  StallM,
  output logic                  ErrM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [1:0]              off_q;
  logic [2:0]              f3_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    access;
  logic                    f3_legal;
  logic                    misaligned;
  logic                    bad;
  logic                    go;
  logic [3:0]              wstrb_n;
  logic [DATA_WIDTH-1:0]   wdata_n;
  logic [DATA_WIDTH-1:0]   sel;
  logic [DATA_WIDTH-1:0]   fmt;

  // Access decode; unsigned variants only exist for loads.
  always_comb begin
    access   = MemReadM ^ MemWriteM;
    f3_legal = 1'b0;
    case (funct3M)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = MemReadM;
      default:          f3_legal = 1'b0;
    endcase
    misaligned = ((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                 ((funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
    bad = (MemReadM & MemWriteM) | (access & (~f3_legal | misaligned));
    go  = access & f3_legal & ~misaligned;
  end

  assign StallM   = ((state == IDLE) & go) | (state == WAIT);
  assign ErrM     = (state == IDLE) & bad;
  assign ReadData = (state == DONE) ? rdata_q : '0;

  always_comb begin
    wstrb_n = 4'b0000;
    wdata_n = WriteDataM;
    if (MemWriteM) begin
      case (funct3M[1:0])
        2'b00: begin
          wstrb_n = 4'b0001 << ALUResultM[1:0];
          wdata_n = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          wstrb_n = 4'b0011 << ALUResultM[1:0];
          wdata_n = {2{WriteDataM[15:0]}};
        end
        default: wstrb_n = 4'b1111;
      endcase
    end
  end

  // Load formatting uses the offset/size latched when the request was issued.
  always_comb begin
    sel = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      F3_B:    fmt = {{24{sel[7]}}, sel[7:0]};
      F3_BU:   fmt = {24'd0, sel[7:0]};
      F3_H:    fmt = {{16{sel[15]}}, sel[15:0]};
      F3_HU:   fmt = {16'd0, sel[15:0]};
      default: fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state     <= WAIT;
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            mem_wstrb <= wstrb_n;
            mem_wdata <= wdata_n;
            off_q     <= ALUResultM[1:0];
            f3_q      <= funct3M;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            rdata_q <= mem_we ? '0 : fmt;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_access_unit
//   Scoreboard bench: byte-level reference memory, randomized memory latency.
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadData;
  logic        StallM, ErrM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  mem_access_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadData(ReadData), .StallM(StallM), .ErrM(ErrM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_rd_q[$];
  int          k_q[$];
  logic [7:0]  ref_mem [0:511];
  logic [31:0] dev_mem [0:127];
  bit          inject_stray = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input int w, input logic [31:0] v);
    dev_mem[w] = v;
    for (int i = 0; i < 4; i++) ref_mem[4*w+i] = v[8*i +: 8];
  endtask

  // Memory device: word array written through byte strobes, latency from k_q.
  initial begin
    bit active;
    int cnt, kcur, idx;
    active = 1'b0; cnt = 0; kcur = 0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      mem_ack = 1'b0;
      if (active && !mem_req) active = 1'b0;
      if (!active && mem_req) begin
        active = 1'b1; cnt = 0;
        kcur = (k_q.size() > 0) ? k_q.pop_front() : 0;
      end
      if (active) begin
        if (cnt >= kcur) begin
          idx = int'(mem_addr[8:2]);
          if (mem_we) begin
            for (int j = 0; j < 4; j++)
              if (mem_wstrb[j]) dev_mem[idx][8*j +: 8] = mem_wdata[8*j +: 8];
            mem_rdata = $urandom();
          end else begin
            mem_rdata = dev_mem[idx];
          end
          mem_ack = 1'b1;
          active  = 1'b0;
        end else begin
          cnt++;
          mem_rdata = $urandom();
        end
      end
      if (inject_stray) begin
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; inject_stray = 1'b0;
      end
    end
  end

  // Monitor: request fields on each new request, ReadData in the cycle after ack.
  initial begin
    bit   prev_req, prev_ack;
    req_t cur;
    prev_req = 1'b0; prev_ack = 1'b0;
    cur = '{we: 1'b0, addr: 32'h0, wstrb: 4'h0, wdata: 32'h0};
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (exp_req_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_req: got addr %h expected no request", mem_addr);
        end else begin
          cur = exp_req_q.pop_front();
          check("req_we", {31'd0, mem_we}, {31'd0, cur.we});
          check("req_addr", mem_addr, cur.addr);
          check("req_wstrb", {28'd0, mem_wstrb}, {28'd0, cur.wstrb});
          if (cur.we) check("req_wdata", mem_wdata, cur.wdata);
        end
      end else if (mem_req && prev_req) begin
        check("hold_addr", mem_addr, cur.addr);
        check("hold_wstrb", {28'd0, mem_wstrb}, {28'd0, cur.wstrb});
      end
      if (prev_ack) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got ReadData %h expected no completion", ReadData);
        end else begin
          check("ReadData", ReadData, exp_rd_q.pop_front());
        end
      end
      prev_ack = mem_req && mem_ack;
      prev_req = mem_req;
    end
  end

  // Reference model: byte-addressed memory, size/sign from funct3.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int k);
    int          size, stalls, ai;
    bit          ok, err;
    req_t        r;
    logic [31:0] v;
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = a; WriteDataM = wd;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ok   = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    ai   = int'(a);
    err  = (rd && wr) || ((rd ^ wr) && !(ok && (ai % size == 0)));
    if (!(rd ^ wr) || err) begin
      @(negedge clk);
      check("ErrM", {31'd0, ErrM}, {31'd0, err});
      check("StallM_idle", {31'd0, StallM}, 32'd0);
      check("ReadData_idle", ReadData, 32'd0);
    end else begin
      r.we = wr; r.addr = a & ~32'd3; r.wstrb = 4'b0000; r.wdata = 32'h0;
      v = 32'h0;
      for (int i = 0; i < size; i++) v |= {24'd0, ref_mem[ai+i]} << (8*i);
      if (!f3[2] && size < 4 && v[8*size-1]) v |= ~((32'd1 << (8*size)) - 32'd1);
      if (wr) begin
        for (int i = 0; i < size; i++) begin
          r.wstrb[(ai % 4) + i] = 1'b1;
          ref_mem[ai+i] = wd[8*i +: 8];
        end
        for (int j = 0; j < 4; j++) r.wdata[8*j +: 8] = wd[8*(j % size) +: 8];
        v = 32'h0;
      end
      exp_req_q.push_back(r);
      exp_rd_q.push_back(v);
      k_q.push_back(k);
      stalls = 0;
      do begin
        @(negedge clk);
        if (StallM) stalls++;
      end while (StallM && stalls < 200);
      check("stall_cycles", stalls, 2 + k);
      check("ErrM_legal", {31'd0, ErrM}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_rdata"}, ReadData, 32'd0);
    check({tag, "_stall"}, {31'd0, StallM}, 32'd0);
    check({tag, "_err"}, {31'd0, ErrM}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          rd, wr;
    int          sel, size;
    logic [2:0]  f3;
    logic [31:0] a;
    rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
    ALUResultM = 32'h0; WriteDataM = 32'h0;
    for (int w = 0; w < 128; w++) preload(w, $urandom());
    @(posedge clk); @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Directed cases
    preload(32'h40, 32'hDEADBEEF);
    do_access(1, 0, 3'b010, 32'h100, 32'h0, 0);
    preload(32'h40, 32'h80FF1234);
    do_access(1, 0, 3'b000, 32'h103, 32'h0, 3);
    do_access(1, 0, 3'b100, 32'h103, 32'h0, 3);
    do_access(0, 1, 3'b001, 32'h22, 32'h0000ABCD, 1);
    do_access(1, 0, 3'b010, 32'h101, 32'h0, 0);
    do_access(0, 1, 3'b001, 32'h03, 32'h12345678, 0);
    do_access(1, 1, 3'b010, 32'h10, 32'h0, 0);
    do_access(0, 1, 3'b100, 32'h10, 32'h0, 0);

    // Reset while waiting on a never-acked load, then a stray ack
    @(posedge clk); #1;
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h80;
    exp_req_q.push_back('{we: 1'b0, addr: 32'h80, wstrb: 4'h0, wdata: 32'h0});
    k_q.push_back(100000);
    repeat (4) @(negedge clk);
    check("stall_in_wait", {31'd0, StallM}, 32'd1);
    @(posedge clk); #1 rst = 1'b1; MemReadM = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1 inject_stray = 1'b1;
    @(negedge clk);
    check_all_zero("stray");
    @(negedge clk);
    check_all_zero("after_stray");

    // Back-to-back store then load of the stored word
    do_access(0, 1, 3'b010, 32'h40, 32'h11223344, 0);
    do_access(1, 0, 3'b101, 32'h42, 32'h0, 0);

    // Randomized traffic
    for (int n = 0; n < 120; n++) begin
      sel = $urandom_range(0, 99);
      rd  = (sel < 45) || (sel >= 85 && sel < 90);
      wr  = (sel >= 45 && sel < 90);
      f3  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom());
      if (rd && !wr && $urandom_range(0, 1) == 1 && f3[1:0] != 2'b10) f3[2] = 1'b1;
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      a = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 9) < 8) a = a & ~(32'(size) - 32'd1);
      if (int'(a) + 4 > 512) a = a - 32'd4;
      do_access(rd, wr, f3, a, $urandom(), $urandom_range(0, 3));
    end

    MemReadM = 1'b0; MemWriteM = 1'b0;
    repeat (3) @(negedge clk);
    check("req_queue_empty", exp_req_q.size(), 32'd0);
    check("rd_queue_empty", exp_rd_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
